// File: rtl/sng_pkg.sv
// sng_pkg: shared widths, LFSR taps, FSM states and stream type for the stochastic number generator.
package sng_pkg;
  localparam int SNG_W = 8;
  localparam int SBS_LEN = 255;
  localparam logic [SNG_W-1:0] LFSR_TAPS = 8'b1011_1000;
  typedef enum logic [1:0] {CAPTURE, GEN, DONE} sng_state_t;
  typedef logic [SBS_LEN-1:0] sbs_t;
  // x^8+x^6+x^5+x^4+1 Fibonacci step: feedback is the XOR of bits 7,5,4,3
  function automatic logic [SNG_W-1:0] lfsr_next(input logic [SNG_W-1:0] s);
    return {s[SNG_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/sng_lfsr8.sv
// lfsr8: maximal-length 8-bit LFSR with synchronous reload and async active-low reset to SEED.
module lfsr8
  import sng_pkg::*;
#(
  parameter logic [SNG_W-1:0] SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [SNG_W-1:0] q
);
  logic [SNG_W-1:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = load ? SEED : step ? lfsr_next(lfsr_q) : lfsr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign q = lfsr_q;
endmodule

// File: rtl/sng.sv
// sng: encodes an 8-bit value as a 255-bit unipolar stochastic bitstream using an LFSR comparator.
// Define SNG_RELOAD_EN to regenerate the stream whenever a changes while in DONE.
module sng
  import sng_pkg::*;
#(
  parameter logic [SNG_W-1:0] lfsr_seed = 8'hB5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SNG_W-1:0] a,
  output sbs_t             a_sbs,
  output logic             done
);
  // an all-zero seed would lock the LFSR
  localparam logic [SNG_W-1:0] SEED = (lfsr_seed == '0) ? 8'h01 : lfsr_seed;
  sng_state_t state_q, state_d;
  logic [SNG_W-1:0] a_q, a_d, idx_q, idx_d, lfsr;
  sbs_t sbs_q, sbs_d;
  logic done_q, done_d, load, step, last;
  lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(load),
    .step(step),
    .q   (lfsr)
  );
  assign last = idx_q == SNG_W'(SBS_LEN - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    idx_d   = idx_q;
    sbs_d   = sbs_q;
    done_d  = done_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      CAPTURE: begin
        a_d     = a;
        state_d = GEN;
      end
      GEN: begin
        sbs_d[idx_q] = lfsr <= a_q;
        step         = 1'b1;
        idx_d        = last ? idx_q : idx_q + 1'b1;
        state_d      = last ? DONE : GEN;
        done_d       = last;
      end
      default: begin
`ifdef SNG_RELOAD_EN
        if (a != a_q) begin
          done_d  = 1'b0;
          sbs_d   = '0;
          load    = 1'b1;
          a_d     = a;
          idx_d   = '0;
          state_d = GEN;
        end
`endif
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= CAPTURE;
      a_q     <= '0;
      idx_q   <= '0;
      sbs_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      idx_q   <= idx_d;
      sbs_q   <= sbs_d;
      done_q  <= done_d;
    end
  assign a_sbs = sbs_q;
  assign done  = done_q;
endmodule

// File: tb/tb_sng.sv
// tb_sng: directed vector table plus reset/input-change sequences for two differently seeded sng instances.
module tb_sng;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a = 8'd0;
  logic [254:0] s0, s1;
  logic d0, d1;
  int n_vec = 0;
  int n_err = 0;
  int e;

  sng #(.lfsr_seed(8'hB5)) u0 (.clk(clk), .rst(rst), .a(a), .a_sbs(s0), .done(d0));
  sng #(.lfsr_seed(8'h01)) u1 (.clk(clk), .rst(rst), .a(a), .a_sbs(s1), .done(d1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [254:0] model(input logic [7:0] seed, input logic [7:0] av);
    logic [7:0] l;
    logic [254:0] r;
    l = seed;
    for (int i = 0; i < 255; i++) begin
      r[i] = l <= av;
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return r;
  endfunction

  function automatic int pc(input logic [254:0] v);
    return $countones(v);
  endfunction

  // assert reset, check outputs clear asynchronously, release on the next falling edge
  task automatic restart(input logic [7:0] av);
    rst = 1'b0;
    a = av;
    #1;
    chk("rst_done0", {31'd0, d0}, 0);
    chk("rst_done1", {31'd0, d1}, 0);
    chk("rst_pop0", pc(s0), 0);
    chk("rst_pop1", pc(s1), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (d0 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    int         pop;
    logic       bit0;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'd0,   0,   1'b0};
    tbl[1] = '{8'd255, 255, 1'b1};
    tbl[2] = '{8'd128, 128, 1'b0};
    tbl[3] = '{8'd200, 200, 1'b1};
    tbl[4] = '{8'd1,   1,   1'b0};
    tbl[5] = '{8'd17,  17,  1'b0};
    #2;
    for (int v = 0; v < 6; v++) begin
      restart(tbl[v].a);
      wait_done(e);
      chk("latency", e, 256);
      chk("done1", {31'd0, d1}, 1);
      chk("pop0", pc(s0), tbl[v].pop);
      chk("pop1", pc(s1), tbl[v].pop);
      chk("bit0", {31'd0, s0[0]}, {31'd0, tbl[v].bit0});
      chk("stream0", pc(s0 ^ model(8'hB5, tbl[v].a)), 0);
      chk("stream1", pc(s1 ^ model(8'h01, tbl[v].a)), 0);
      if (tbl[v].a == 8'd200) begin
        chk("differ", {31'd0, s0 != s1}, 1);
        chk("and_pop", pc(s0 & s1), pc(model(8'hB5, 8'd200) & model(8'h01, 8'd200)));
        chk("and_range", {31'd0, pc(s0 & s1) >= 137 && pc(s0 & s1) <= 177}, 1);
      end
    end
    // reset asserted right after edge 100 aborts generation
    restart(8'd50);
    repeat (99) @(negedge clk);
    @(posedge clk);
    #1;
    restart(8'd17);
    wait_done(e);
    chk("mid_latency", e, 256);
    chk("mid_pop", pc(s0), 17);
    chk("mid_stream", pc(s0 ^ model(8'hB5, 8'd17)), 0);
    // input changes during GEN (edge 10) and in DONE (edge 300)
    restart(8'd50);
    repeat (10) @(negedge clk);
    a = 8'd99;
    repeat (10) @(negedge clk);
    a = 8'd50;
    repeat (236) @(negedge clk);
    chk("chg_done256", {31'd0, d0}, 1);
    chk("chg_pop256", pc(s0), 50);
    repeat (43) @(negedge clk);
    a = 8'd99;
    @(negedge clk);
`ifdef SNG_RELOAD_EN
    chk("rl_done300", {31'd0, d0}, 0);
    chk("rl_pop300", pc(s0), 0);
    repeat (254) @(negedge clk);
    chk("rl_done554", {31'd0, d0}, 0);
    @(negedge clk);
    chk("rl_done555", {31'd0, d0}, 1);
    chk("rl_pop555", pc(s0), 99);
    chk("rl_stream", pc(s0 ^ model(8'hB5, 8'd99)), 0);
    chk("rl_pop1", pc(s1), 99);
`else
    chk("hold_done300", {31'd0, d0}, 1);
    chk("hold_pop300", pc(s0), 50);
    repeat (255) @(negedge clk);
    chk("hold_done555", {31'd0, d0}, 1);
    chk("hold_pop555", pc(s0), 50);
    chk("hold_stream", pc(s0 ^ model(8'hB5, 8'd50)), 0);
    chk("hold_pop1", pc(s1), 50);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
